// File: rtl/sensor_packet_buffer_pkg.sv
// Shared definitions for the sensor packet buffer.
// Default geometry (sensor count, slot depth, fill byte) and FSM state encodings.
// Ports: none (package).
package sensor_packet_buffer_pkg;

  localparam int DEF_LOG_SENSORS = 3;
  localparam int DEF_LOG_PACKET  = 4;
  localparam int SENSORS         = 2 ** DEF_LOG_SENSORS;
  localparam int DEPTH           = 2 ** DEF_LOG_PACKET;
  localparam logic [7:0] FILL_BYTE_DEF = 8'h76;

  typedef enum logic {
    W_IDLE,
    W_PKT
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_READ,
    R_EMPTY
  } rstate_t;

endpackage

// File: rtl/sensor_packet_buffer_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Latency: read address in cycle N, data on o_rdata in N+1. No backpressure.
// Ports: clk, i_we/i_waddr/i_wdata (write), i_re/i_raddr (read), o_rdata.
module packet_ram_sdp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  (* ramstyle = "M9K" *) logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_q;

  // Contents are deliberately never reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/sensor_packet_buffer.sv
// Per-sensor single-packet store: byte-stream writes, whole-packet streamed reads.
// Latency: empty-slot beat 1 cycle after read accept, packet bytes from 2 cycles after.
// Backpressure: wr_ready drops only while a read is active on the write's sensor;
//   rd_ready drops while busy or while a write targets the requested sensor.
// Ports: clk/rst; wr_* byte-stream write side with wr_overflow pulse;
//   rd_* request/stream read side; pkt_avail per-sensor committed-packet flags.
module sensor_packet_buffer
  import sensor_packet_buffer_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int LOG_SENSORS = DEF_LOG_SENSORS,
  parameter int LOG_PACKET  = DEF_LOG_PACKET,
  parameter logic [DATA_WIDTH-1:0] FILL_BYTE = DATA_WIDTH'(FILL_BYTE_DEF)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [LOG_SENSORS-1:0]    wr_sensor,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      wr_last,
  output logic                      wr_overflow,
  input  logic                      rd_start,
  input  logic [LOG_SENSORS-1:0]    rd_sensor,
  output logic                      rd_ready,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid,
  output logic                      rd_last,
  output logic                      rd_empty,
  output logic [2**LOG_SENSORS-1:0] pkt_avail
);

  localparam int NSENS = 2 ** LOG_SENSORS;
  localparam int AW    = LOG_SENSORS + LOG_PACKET;
  localparam logic [LOG_PACKET:0] DEPTH_L = (LOG_PACKET+1)'(2 ** LOG_PACKET);

  // Write side state
  wstate_t                  r_wstate;
  logic [LOG_SENSORS-1:0]   r_cur_wsensor;
  logic [LOG_PACKET:0]      r_bidx;          // saturates at DEPTH once bytes start dropping
  logic                     r_trunc;
  logic                     r_wr_overflow;

  // Per-sensor bookkeeping
  logic [LOG_PACKET:0]      r_len [NSENS];
  logic [NSENS-1:0]         r_avail;

  // Read side state
  rstate_t                  r_rstate;
  logic [LOG_SENSORS-1:0]   r_rsensor;
  logic [LOG_PACKET:0]      r_rlen;
  logic [LOG_PACKET-1:0]    r_ridx;
  logic                     r_rd_valid;
  logic                     r_rd_last;
  logic                     r_rd_empty;

  logic [LOG_SENSORS-1:0]   w_wsensor;
  logic                     w_wr_ready;
  logic                     w_wr_acc;
  logic                     w_in_range;
  logic                     w_rd_ready;
  logic                     w_rd_acc;
  logic                     w_last_rd;
  logic [DATA_WIDTH-1:0]    w_ram_q;

  // A packet in flight keeps its latched sensor; only the first beat looks at wr_sensor.
  assign w_wsensor  = (r_wstate == W_PKT) ? r_cur_wsensor : wr_sensor;
  assign w_in_range = (r_bidx < DEPTH_L);
  assign w_wr_ready = !((r_rstate != R_IDLE) && (r_rsensor == w_wsensor));
  assign w_wr_acc   = wr_valid && w_wr_ready;

  // A write beat offered this cycle also blocks a read of the same slot, so
  // a read can never start on a slot that is mid-update.
  assign w_rd_ready = (r_rstate == R_IDLE) &&
                      !(((r_wstate == W_PKT) || wr_valid) && (w_wsensor == rd_sensor));
  assign w_rd_acc   = rd_start && w_rd_ready;

  assign w_last_rd  = (r_rstate == R_READ) && ({1'b0, r_ridx} == (r_rlen - 1'b1));

  packet_ram_sdp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_acc && w_in_range),
    .i_waddr ({w_wsensor, r_bidx[LOG_PACKET-1:0]}),
    .i_wdata (wr_data),
    .i_re    (r_rstate == R_READ),
    .i_raddr ({r_rsensor, r_ridx}),
    .o_rdata (w_ram_q)
  );

  // Write FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate      <= W_IDLE;
      r_cur_wsensor <= '0;
      r_bidx        <= '0;
      r_trunc       <= 1'b0;
      r_wr_overflow <= 1'b0;
    end else begin
      r_wr_overflow <= 1'b0;
      if (w_wr_acc) begin
        if (wr_last) begin
          r_wstate      <= W_IDLE;
          r_bidx        <= '0;
          r_trunc       <= 1'b0;
          // The last beat itself may be the first one dropped.
          r_wr_overflow <= r_trunc || !w_in_range;
        end else begin
          r_wstate      <= W_PKT;
          r_cur_wsensor <= w_wsensor;
          if (w_in_range) r_bidx  <= r_bidx + 1'b1;
          else            r_trunc <= 1'b1;
        end
      end
    end
  end

  // Lengths and availability. A commit and a read-complete never hit the
  // same sensor in one cycle because of the collision interlock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_avail <= '0;
      for (int s = 0; s < NSENS; s++) r_len[s] <= '0;
    end else begin
      if (w_last_rd) r_avail[r_rsensor] <= 1'b0;
      if (w_wr_acc && wr_last) begin
        r_len[w_wsensor]   <= w_in_range ? (r_bidx + 1'b1) : DEPTH_L;
        r_avail[w_wsensor] <= 1'b1;
      end
    end
  end

  // Read FSM. Output flags are registered alongside the RAM's read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate   <= R_IDLE;
      r_rsensor  <= '0;
      r_rlen     <= '0;
      r_ridx     <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_empty <= 1'b0;
    end else begin
      r_rd_valid <= (r_rstate == R_READ);
      r_rd_last  <= w_last_rd;
      r_rd_empty <= 1'b0;
      case (r_rstate)
        R_IDLE: begin
          if (w_rd_acc) begin
            r_rsensor <= rd_sensor;
            r_rlen    <= r_len[rd_sensor];
            r_ridx    <= '0;
            if (r_avail[rd_sensor]) begin
              r_rstate <= R_READ;
            end else begin
              r_rstate   <= R_EMPTY;
              r_rd_valid <= 1'b1;
              r_rd_last  <= 1'b1;
              r_rd_empty <= 1'b1;
            end
          end
        end
        R_READ: begin
          r_ridx <= r_ridx + 1'b1;
          if (w_last_rd) r_rstate <= R_IDLE;
        end
        R_EMPTY: r_rstate <= R_IDLE;
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign wr_ready    = w_wr_ready;
  assign rd_ready    = w_rd_ready;
  assign wr_overflow = r_wr_overflow;
  assign rd_valid    = r_rd_valid;
  assign rd_last     = r_rd_last;
  assign rd_empty    = r_rd_empty;
  assign pkt_avail   = r_avail;
  // Gated so the bus reads 0 between beats; the RAM register itself is never reset.
  assign rd_data     = r_rd_valid ? (r_rd_empty ? FILL_BYTE : w_ram_q) : '0;

endmodule

// File: tb/tb_sensor_packet_buffer.sv
// Self-checking bench for sensor_packet_buffer with a beat scoreboard.
// Latency and stream continuity checked per read; content checked by the monitor.
// Ports: none (top-level bench).
module tb_sensor_packet_buffer;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       e;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid, wr_ready, wr_last, wr_overflow;
  logic [2:0] wr_sensor, rd_sensor;
  logic [7:0] wr_data, rd_data;
  logic       rd_start, rd_ready, rd_valid, rd_last, rd_empty;
  logic [7:0] pkt_avail;

  int checks = 0;
  int errors = 0;
  int ovf_cnt = 0;
  bit acc_flag = 1'b0;

  beat_t      sb [$];
  logic [7:0] mdl_data [8][$];
  logic [7:0] mdl_avail = '0;

  always #5 clk = ~clk;

  sensor_packet_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_sensor   (wr_sensor),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .wr_overflow (wr_overflow),
    .rd_start    (rd_start),
    .rd_sensor   (rd_sensor),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_last     (rd_last),
    .rd_empty    (rd_empty),
    .pkt_avail   (pkt_avail)
  );

  // Scoreboard monitor: every presented beat must match the next expected one.
  always @(negedge clk) begin
    if (wr_overflow === 1'b1) ovf_cnt++;
    if (rd_valid === 1'b1) begin
      beat_t obs;
      beat_t exp;
      obs = '{d: rd_data, l: rd_last, e: rd_empty};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rd_beat_unexpected: got data=%h last=%b empty=%b, required no beat",
                 obs.d, obs.l, obs.e);
      end else begin
        exp = sb.pop_front();
        if (obs !== exp) begin
          errors++;
          $display("FAIL rd_beat: got data=%h last=%b empty=%b, required data=%h last=%b empty=%b",
                   obs.d, obs.l, obs.e, exp.d, exp.l, exp.e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [2:0] s, input logic [7:0] d, input bit last);
    int guard = 0;
    wr_valid = 1'b1; wr_sensor = s; wr_data = d; wr_last = last;
    #1;
    while (wr_ready !== 1'b1 && guard < 200) begin step(); guard++; end
    if (guard >= 200) begin
      checks++; errors++;
      $display("FAIL wr_ready_timeout: wr_ready=%b, required 1 within 200 cycles", wr_ready);
    end
    step();
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic write_pkt(input logic [2:0] s, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) send_beat(s, base + 8'(i), (i == n - 1));
    mdl_data[s].delete();
    for (int i = 0; i < n && i < 16; i++) mdl_data[s].push_back(base + 8'(i));
    mdl_avail[s] = 1'b1;
    checks++;
    if (wr_overflow !== (n > 16)) begin
      errors++;
      $display("FAIL wr_overflow_after_last: got %b, required %b", wr_overflow, (n > 16));
    end
  endtask

  task automatic read_pkt(input logic [2:0] s);
    int guard = 0;
    int n;
    int lat;
    int cyc;
    rd_sensor = s; rd_start = 1'b1;
    #1;
    while (rd_ready !== 1'b1 && guard < 200) begin step(); guard++; end
    if (guard >= 200) begin
      checks++; errors++;
      $display("FAIL rd_ready_timeout: rd_ready=%b, required 1 within 200 cycles", rd_ready);
    end
    step();
    rd_start = 1'b0;
    if (mdl_avail[s]) begin
      n = mdl_data[s].size();
      lat = 2;
      for (int i = 0; i < n; i++) sb.push_back('{d: mdl_data[s][i], l: (i == n - 1), e: 1'b0});
    end else begin
      n = 1;
      lat = 1;
      sb.push_back('{d: 8'h76, l: 1'b1, e: 1'b1});
    end
    mdl_avail[s] = 1'b0;
    acc_flag = 1'b1;
    cyc = 1;
    while (rd_valid !== 1'b1 && cyc < 20) begin step(); cyc++; end
    checks++;
    if (cyc != lat) begin
      errors++;
      $display("FAIL rd_latency s%0d: first beat %0d cycles after accept, required %0d", s, cyc, lat);
    end
    for (int i = 1; i < n; i++) begin
      step();
      checks++;
      if (rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL rd_stream_gap s%0d beat %0d: rd_valid=%b, required 1", s, i, rd_valid);
      end
    end
    step();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_after_stream s%0d: rd_valid=%b, required 0", s, rd_valid);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rd_beats_missing s%0d: %0d beats outstanding, required 0", s, sb.size());
      sb.delete();
    end
    checks++;
    if (pkt_avail !== mdl_avail) begin
      errors++;
      $display("FAIL pkt_avail_after_read s%0d: got %h, required %h", s, pkt_avail, mdl_avail);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wr_valid = 1'b0; wr_sensor = '0; wr_data = '0; wr_last = 1'b0;
    rd_start = 1'b0; rd_sensor = '0;
    step(); step();
    rst = 1'b0;
    #1;
    checks++;
    if ({rd_valid, rd_last, rd_empty, wr_overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got valid/last/empty/ovf=%b%b%b%b, required 0000",
               rd_valid, rd_last, rd_empty, wr_overflow);
    end
    checks++;
    if (rd_data !== 8'h00 || pkt_avail !== 8'h00) begin
      errors++;
      $display("FAIL reset_data_avail: got rd_data=%h pkt_avail=%h, required 00 00", rd_data, pkt_avail);
    end
    checks++;
    if (wr_ready !== 1'b1 || rd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got wr_ready=%b rd_ready=%b, required 1 1", wr_ready, rd_ready);
    end
  endtask

  task automatic test_basic;
    write_pkt(3'd2, 5, 8'h10);
    checks++;
    if (pkt_avail !== 8'h04) begin
      errors++;
      $display("FAIL basic_avail: got %h, required 04", pkt_avail);
    end
    read_pkt(3'd2);
  endtask

  task automatic test_empty_read;
    read_pkt(3'd5);
  endtask

  task automatic test_overflow;
    int ovf0;
    ovf0 = ovf_cnt;
    write_pkt(3'd1, 20, 8'h30);
    step(); step(); step();
    checks++;
    if (ovf_cnt - ovf0 != 1) begin
      errors++;
      $display("FAIL overflow_pulses: got %0d pulses, required 1", ovf_cnt - ovf0);
    end
    read_pkt(3'd1);
  endtask

  task automatic test_overwrite;
    write_pkt(3'd0, 3, 8'hA0);
    write_pkt(3'd0, 2, 8'hB0);
    checks++;
    if (pkt_avail !== mdl_avail) begin
      errors++;
      $display("FAIL overwrite_avail: got %h, required %h", pkt_avail, mdl_avail);
    end
    read_pkt(3'd0);
  endtask

  task automatic test_collision;
    write_pkt(3'd3, 8, 8'h50);
    acc_flag = 1'b0;
    fork
      read_pkt(3'd3);
      begin
        wait (acc_flag);
        for (int c = 1; c <= 8; c++) begin
          bit exp_rdy;
          exp_rdy = (c >= 3 && c <= 6);
          wr_valid = 1'b1;
          if (exp_rdy) begin
            wr_sensor = 3'd4; wr_data = 8'hC0 + 8'(c); wr_last = (c == 6);
          end else begin
            wr_sensor = 3'd3; wr_data = 8'hEE; wr_last = 1'b0;
          end
          #1;
          checks++;
          if (wr_ready !== exp_rdy) begin
            errors++;
            $display("FAIL collision_wr_ready cycle %0d sensor %0d: got %b, required %b",
                     c, wr_sensor, wr_ready, exp_rdy);
          end
          step();
          if (c == 6) begin
            mdl_data[4].delete();
            for (int i = 3; i <= 6; i++) mdl_data[4].push_back(8'hC0 + 8'(i));
            mdl_avail[4] = 1'b1;
          end
        end
        wr_valid = 1'b0; wr_last = 1'b0;
      end
    join
    read_pkt(3'd4);
  endtask

  task automatic test_reset_mid_read;
    int guard = 0;
    write_pkt(3'd6, 6, 8'h60);
    rd_sensor = 3'd6; rd_start = 1'b1;
    #1;
    while (rd_ready !== 1'b1 && guard < 200) begin step(); guard++; end
    if (guard >= 200) begin
      checks++; errors++;
      $display("FAIL rd_ready_timeout_mid: rd_ready=%b, required 1", rd_ready);
    end
    step();
    rd_start = 1'b0;
    for (int i = 0; i < 3; i++) sb.push_back('{d: 8'h60 + 8'(i), l: 1'b0, e: 1'b0});
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mdl_avail = '0;
    checks++;
    if ({rd_valid, rd_last, rd_empty} !== 3'b000 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL midreset_outputs: got valid/last/empty=%b%b%b data=%h, required 000 00",
               rd_valid, rd_last, rd_empty, rd_data);
    end
    checks++;
    if (pkt_avail !== 8'h00 || rd_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_state: got pkt_avail=%h rd_ready=%b, required 00 1", pkt_avail, rd_ready);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL midreset_beats: %0d of first 3 beats missing, required 0", sb.size());
      sb.delete();
    end
    step(); step();
    read_pkt(3'd6);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_read();
    test_overflow();
    test_overwrite();
    test_collision();
    test_reset_mid_read();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
